// File: rtl/cache_ctrl.sv
// cache_ctrl: miss-handling controller for a two-way set-associative data cache.
//
// It holds the tag/valid/dirty/LRU state in flip-flops, detects hits in the same
// cycle as the request, and sequences two kinds of burst over the main-memory
// handshake:
//   - write-back: victim line read from SRAM port B and sent to memory (store_o)
//   - refill:     line fetched from memory and written into SRAM port B (load_o)
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   enable_i, read_in_i,
//   write_in_i, addr_in_i         core request (write wins over read)
//   complete_i                    memory accepted/produced one word this cycle
//   cache_hit_o, stall_o          hit indication / hold request while servicing a miss
//   way_sel_o, read_o             port-A read mux select and output enable
//   write_0_o, write_1_o          port-A word write strobe per way
//   load_0_o, load_1_o            port-B refill write strobe per way
//   cnt_o                         burst word index (port-B address low bits)
//   load_o, store_o, addr_out_o   main-memory request and word address
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | serve hits combinationally; on a miss pick and latch a victim
// WB     | write the dirty victim line back, one word per complete
// REFILL | fetch the requested line into the victim way, one word per complete

module cache_ctrl #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic                          read_in_i,
    input  logic                          write_in_i,
    input  logic [31:0]                   addr_in_i,
    input  logic                          complete_i,
    output logic                          cache_hit_o,
    output logic                          stall_o,
    output logic                          way_sel_o,
    output logic                          read_o,
    output logic                          write_0_o,
    output logic                          write_1_o,
    output logic                          load_0_o,
    output logic                          load_1_o,
    output logic [$clog2(LINE_WORDS)-1:0] cnt_o,
    output logic                          load_o,
    output logic                          store_o,
    output logic [31:0]                   addr_out_o
);

    localparam int CNT_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = 2 + CNT_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_REFILL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               victim_q, victim_d;

    logic [TAG_W-1:0]   tag_q   [2][SETS];
    logic [SETS-1:0]    valid_q [2];
    logic [SETS-1:0]    dirty_q [2];
    logic [SETS-1:0]    lru_q;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req, hit0, hit1, any_hit, hit_way;
    logic               victim_pick, last_word;
    logic               lru_upd, lru_val, dirty_set, fill_done;
    logic               unused_addr_bits;

    assign idx     = addr_in_i[TAG_LSB-1:IDX_LSB];
    assign req_tag = addr_in_i[31:TAG_LSB];
    assign req     = enable_i & (read_in_i | write_in_i);
    assign hit0    = valid_q[0][idx] & (tag_q[0][idx] == req_tag);
    assign hit1    = valid_q[1][idx] & (tag_q[1][idx] == req_tag);
    assign any_hit = hit0 | hit1;
    assign hit_way = ~hit0;

    // Fill empty ways first (way 0 before way 1); only evict by LRU when both are in use.
    assign victim_pick = ~valid_q[0][idx] ? 1'b0 :
                         ~valid_q[1][idx] ? 1'b1 : lru_q[idx];

    assign last_word = (cnt_q == CNT_W'(LINE_WORDS - 1));

    // Word offset is consumed by the SRAM port-A address path, not here.
    assign unused_addr_bits = ^addr_in_i[IDX_LSB-1:0];

    assign cnt_o = cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        victim_d    = victim_q;
        cache_hit_o = 1'b0;
        stall_o     = 1'b0;
        way_sel_o   = 1'b0;
        read_o      = 1'b0;
        write_0_o   = 1'b0;
        write_1_o   = 1'b0;
        load_0_o    = 1'b0;
        load_1_o    = 1'b0;
        load_o      = 1'b0;
        store_o     = 1'b0;
        addr_out_o  = '0;
        lru_upd     = 1'b0;
        lru_val     = 1'b0;
        dirty_set   = 1'b0;
        fill_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (any_hit) begin
                        cache_hit_o = 1'b1;
                        way_sel_o   = hit_way;
                        lru_upd     = 1'b1;
                        lru_val     = ~hit_way;
                        if (write_in_i) begin
                            write_0_o = ~hit_way;
                            write_1_o = hit_way;
                            dirty_set = 1'b1;
                        end else begin
                            read_o = 1'b1;
                        end
                    end else begin
                        stall_o  = 1'b1;
                        victim_d = victim_pick;
                        cnt_d    = '0;
                        if (valid_q[victim_pick][idx] && dirty_q[victim_pick][idx]) begin
                            state_d = S_WB;
                        end else begin
                            state_d = S_REFILL;
                        end
                    end
                end
            end

            S_WB: begin
                stall_o    = 1'b1;
                store_o    = 1'b1;
                way_sel_o  = victim_q;
                addr_out_o = {tag_q[victim_q][idx], idx, cnt_q, 2'b00};
                if (complete_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end
            end

            S_REFILL: begin
                stall_o    = 1'b1;
                load_o     = 1'b1;
                addr_out_o = {req_tag, idx, cnt_q, 2'b00};
                load_0_o   = complete_i & ~victim_q;
                load_1_o   = complete_i & victim_q;
                if (complete_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        cnt_d     = '0;
                        fill_done = 1'b1;
                        lru_upd   = 1'b1;
                        lru_val   = ~victim_q;
                        state_d   = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            victim_q   <= 1'b0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            if (lru_upd) begin
                lru_q[idx] <= lru_val;
            end
            if (dirty_set) begin
                dirty_q[hit_way][idx] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= 1'b0;
            end
        end
    end

    // Tags need no reset: they are only looked at through a set valid bit, and they
    // change only on the final refill word, so an abandoned burst leaves them intact.
    always_ff @(posedge clk_i) begin
        if (fill_done) begin
            tag_q[victim_q][idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed testbench for cache_ctrl.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.

module tb_cache_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i, read_in_i, write_in_i, complete_i;
    logic [31:0] addr_in_i;
    logic        cache_hit_o, stall_o, way_sel_o, read_o;
    logic        write_0_o, write_1_o, load_0_o, load_1_o;
    logic [3:0]  cnt_o;
    logic        load_o, store_o;
    logic [31:0] addr_out_o;

    int checks   = 0;
    int failures = 0;

    cache_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .read_in_i   (read_in_i),
        .write_in_i  (write_in_i),
        .addr_in_i   (addr_in_i),
        .complete_i  (complete_i),
        .cache_hit_o (cache_hit_o),
        .stall_o     (stall_o),
        .way_sel_o   (way_sel_o),
        .read_o      (read_o),
        .write_0_o   (write_0_o),
        .write_1_o   (write_1_o),
        .load_0_o    (load_0_o),
        .load_1_o    (load_1_o),
        .cnt_o       (cnt_o),
        .load_o      (load_o),
        .store_o     (store_o),
        .addr_out_o  (addr_out_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic en, input logic rd, input logic wr, input logic [31:0] a);
        enable_i   = en;
        read_in_i  = rd;
        write_in_i = wr;
        addr_in_i  = a;
    endtask

    // One 16-word burst; gap idle cycles (complete low) precede each word.
    task automatic burst(input bit is_wb, input logic [31:0] base, input logic way, input int gap);
        int pulses = 0;
        int stray  = 0;
        for (int k = 0; k < 16; k++) begin
            for (int g = 0; g < gap; g++) begin
                complete_i = 1'b0;
                @(negedge clk_i);
                chk("hold_addr", addr_out_o, base + 32'(4 * k));
                chk("hold_cnt", 32'(cnt_o), 32'(k));
                stray += int'(load_0_o) + int'(load_1_o);
                next_cycle();
            end
            complete_i = 1'b1;
            @(negedge clk_i);
            chk(is_wb ? "wb_addr" : "rf_addr", addr_out_o, base + 32'(4 * k));
            chk("burst_cnt", 32'(cnt_o), 32'(k));
            chk("burst_store", 32'(store_o), 32'(is_wb));
            chk("burst_load", 32'(load_o), 32'(!is_wb));
            chk("burst_stall", 32'(stall_o), 32'd1);
            if (is_wb) begin
                chk("wb_way_sel", 32'(way_sel_o), 32'(way));
                stray += int'(load_0_o) + int'(load_1_o);
            end else begin
                pulses += way ? int'(load_1_o) : int'(load_0_o);
                stray  += way ? int'(load_0_o) : int'(load_1_o);
            end
            stray += int'(write_0_o) + int'(write_1_o);
            next_cycle();
        end
        complete_i = 1'b0;
        if (!is_wb) chk("load_pulses", 32'(pulses), 32'd16);
        chk("stray_strobes", 32'(stray), 32'd0);
    endtask

    // Miss cycle, optional write-back of wb_base, refill into way, then the retried hit.
    task automatic miss(input logic [31:0] a, input bit exp_wb, input logic [31:0] wb_base,
                        input logic way, input int gap, input bit drop_en);
        set_req(1'b1, 1'b1, 1'b0, a);
        @(negedge clk_i);
        chk("miss_stall", 32'(stall_o), 32'd1);
        chk("miss_hit", 32'(cache_hit_o), 32'd0);
        chk("miss_idle_load", 32'(load_o | store_o), 32'd0);
        next_cycle();
        if (drop_en) enable_i = 1'b0;
        if (exp_wb) burst(1'b1, wb_base, way, gap);
        burst(1'b0, {a[31:6], 6'b0}, way, gap);
        enable_i = 1'b1;
        @(negedge clk_i);
        chk("retry_hit", 32'(cache_hit_o), 32'd1);
        chk("retry_way", 32'(way_sel_o), 32'(way));
        chk("retry_stall", 32'(stall_o), 32'd0);
        chk("retry_idle_load", 32'(load_o | store_o), 32'd0);
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic hit_check(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                             input logic way);
        set_req(1'b1, rd, wr, a);
        @(negedge clk_i);
        chk({tag, "_hit"}, 32'(cache_hit_o), 32'd1);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_way"}, 32'(way_sel_o), 32'(way));
        chk({tag, "_read"}, 32'(read_o), 32'(!wr));
        chk({tag, "_wr0"}, 32'(write_0_o), 32'(wr && !way));
        chk({tag, "_wr1"}, 32'(write_1_o), 32'(wr && way));
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, a);
    endtask

    initial begin
        rst_ni     = 1'b0;
        complete_i = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 32'h0);
        #3;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        chk("rst_addr_out", addr_out_o, 32'h0);
        chk("rst_load_store", 32'(load_o | store_o), 32'd0);
        #9 rst_ni = 1'b1;
        next_cycle();

        // clean miss into way 0, then write hit marks it dirty
        miss(32'h0000_0040, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        hit_check("wr_hit", 1'b0, 1'b1, 32'h0000_0048, 1'b0);

        // same set, new tag: empty way 1 is filled without a write-back; enable dropped mid-burst
        miss(32'h0000_0440, 1'b0, 32'h0, 1'b1, 0, 1'b1);

        // LRU now points at dirty way 0: write-back of 0x40 line then refill of 0x840
        miss(32'h0000_0840, 1'b1, 32'h0000_0040, 1'b0, 0, 1'b0);
        hit_check("rd_way1", 1'b1, 1'b0, 32'h0000_0440, 1'b1);

        // way 0 is LRU and clean after its refill: no write-back; slow memory
        miss(32'h0000_0C40, 1'b0, 32'h0, 1'b0, 3, 1'b0);

        // reset in the middle of a refill at cnt = 7
        set_req(1'b1, 1'b1, 1'b0, 32'h0000_1000);
        @(negedge clk_i);
        chk("pre_rst_stall", 32'(stall_o), 32'd1);
        next_cycle();
        complete_i = 1'b1;
        repeat (7) @(posedge clk_i);
        #1;
        complete_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_cnt", 32'(cnt_o), 32'd7);
        chk("pre_rst_load", 32'(load_o), 32'd1);
        #1;
        enable_i = 1'b0;
        rst_ni   = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_cnt", 32'(cnt_o), 32'd0);
        chk("midrst_load", 32'(load_o | store_o), 32'd0);
        chk("midrst_addr_out", addr_out_o, 32'h0);
        #1 rst_ni = 1'b1;
        next_cycle();

        // all lines invalid again: same address misses, and a previously valid line misses too
        miss(32'h0000_1000, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        miss(32'h0000_0440, 1'b0, 32'h0, 1'b0, 0, 1'b0);

        // write wins over read on a hit
        hit_check("rdwr_hit", 1'b1, 1'b1, 32'h0000_0444, 1'b0);

        // no enable: nothing happens
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_0444);
        @(negedge clk_i);
        chk("noen_hit", 32'(cache_hit_o), 32'd0);
        chk("noen_stall", 32'(stall_o), 32'd0);
        chk("noen_strobes", 32'({read_o, write_0_o, write_1_o}), 32'd0);
        next_cycle();
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_5000);
        @(negedge clk_i);
        chk("noen_miss_stall", 32'(stall_o), 32'd0);
        next_cycle();

        hit_check("rd_set0", 1'b1, 1'b0, 32'h0000_1004, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Miss-handling controller for the two-way, 16-set, 16-words-per-line data cache built from two dual-port 256x32 SRAMs. It holds the tag, valid, dirty and LRU state, detects hits, and sequences write-back bursts (port B read to main memory) and refill bursts (main memory to port B write). It sits between the MIPS core's read/write request and the main-memory `load`/`store`/`complete` handshake, and drives the per-way SRAM strobes and the burst word counter.

## Interface
- `SETS`, 16: number of sets; the index is `addr_in[9:6]`.
- `LINE_WORDS`, 16: words per line; the word offset is `addr_in[5:2]`; `cnt` width is log2(`LINE_WORDS`).
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `Enable  in  1`: request qualifier from the core.
- `read_in  in  1`: read request. Qualified by `Enable`.
- `write_in  in  1`: write request. Qualified by `Enable`. Wins over `read_in` if both are asserted.
- `addr_in  in  32`: request address. Tag is `[31:10]` (22 bits). The core holds it stable while `stall` = 1.
- `complete  in  1`: main memory has accepted or produced one word this cycle.
- `cache_hit  out  1`: request hits; data is valid this cycle.
- `stall  out  1`: a miss is being serviced; the core must hold its request.
- `way_sel  out  1`: way for the port-A read mux and the port-B store mux.
- `read  out  1`: port-A output enable.
- `write_0`, `write_1`  `out  1`: port-A word write strobe for way 0 / way 1.
- `load_0`, `load_1`  `out  1`: port-B refill write strobe for way 0 / way 1.
- `cnt  out  4`: burst word index; forms the port-B address `{addr_in[9:6], cnt}`.
- `load  out  1`: refill request to main memory.
- `store  out  1`: write-back request to main memory.
- `addr_out  out  32`: main-memory word address.

## Operation
- **Per-set state:** per way, `tag[21:0]`, `valid`, `dirty`; per set, `lru` (the way to evict next). All arrays are flip-flops.
- **Request and hit detection:**
  - `req` = `Enable & (read_in | write_in)`.
  - `hitN` = `valid[N][idx] & tag[N][idx] == addr_in[31:10]`.
  - `cache_hit` = `req & (hit0 | hit1)` in IDLE only.
- **States:**
  - **IDLE**
    - Read hit: `read` = 1; `way_sel` = hit way.
    - Write hit: `write_N` = 1 for the hit way; `dirty` for that way is set at the edge.
    - Any hit: `lru[idx]` ← the other way at the edge.
    - Miss (`req` & no hit): choose the victim. Order is invalid way 0, then invalid way 1, else `lru[idx]`. Latch the victim. Next state is WB if the victim is valid and dirty, else REFILL. `cnt` ← 0.
  - **WB**
    - `store` = 1; `way_sel` = victim.
    - `addr_out` = `{tag[victim][idx], idx, cnt, 2'b00}`.
    - Each cycle with `complete` = 1: `cnt` ← `cnt` + 1.
    - `complete` with `cnt` == 15: `cnt` ← 0, go to REFILL.
  - **REFILL**
    - `load` = 1.
    - `addr_out` = `{addr_in[31:10], idx, cnt, 2'b00}`.
    - `load_N` (victim way) = `complete`.
    - `complete` with `cnt` == 15:
      - `tag` ← `addr_in[31:10]`, `valid` ← 1, `dirty` ← 0.
      - `lru[idx]` ← the other way.
      - `cnt` ← 0; go to IDLE, where the retried request hits.
- **Stall:** `stall` = 1 in WB and REFILL, and in IDLE on a miss cycle.
- **Counter rule:** `cnt` advances only on `complete` and wraps 15 → 0 only at a state exit.
- **Request changes during a miss:** deasserting `Enable`, `read_in` or `write_in` during WB/REFILL has no effect; the burst completes. Violating the `addr_in` hold rule is illegal.
- **Strobe exclusivity:**
  - `load` and `store` are never asserted together.
  - `write_N` and `load_N` are never asserted in the same cycle.
  - No strobe is asserted for both ways at once.

## Timing
- **Reset** (`rst` = 0, asynchronous, any state):
  - State → IDLE; `cnt` = 0.
  - All `valid`, `dirty` and `lru` bits = 0.
  - All outputs = 0; `addr_out` = 0.
  - Reset in the middle of a burst abandons the burst with no partial tag update.
- **Hit latency:** 0 cycles. The strobe and `cache_hit` are combinational in the same cycle as the request.
- **Clean miss:** the miss cycle, then a REFILL of 16 cycles with `complete` held high, then IDLE. The hit lands 18 cycles after the request.
- **Dirty miss:** adds 16 WB cycles before the REFILL (34 cycles total).
- **Waits:** `complete` may stay low for any number of cycles. `cnt`, `addr_out` and the strobes hold until it rises.
- **Outputs in IDLE:** `load`/`store` are 0 in IDLE.

## Test plan
- **Reset, then read 0x0000_0040:** miss; `stall` = 1; REFILL with `addr_out` 0x40, 0x44 … 0x7C over 16 completes; `load_0` pulses 16 times; then `cache_hit` = 1 and `way_sel` = 0.
- **Write hit on 0x0000_0048:** `write_0` = 1 that cycle, no stall; next, read 0x0000_0440 (same set, different tag) → refills way 1 with `load_1`, no WB.
- **Dirty eviction:** read 0x0000_0840 (set 1, LRU = way 0, dirty) → WB with `store` = 1, `addr_out` 0x40 … 0x7C, then REFILL at 0x840 … 0x87C; way 0 tag updated, dirty = 0.
- **Irregular `complete`:** low for 3 cycles between each word during REFILL → `cnt` and `addr_out` hold; exactly 16 `load_N` pulses.
- **Reset mid-REFILL at `cnt` = 7:** all valid = 0, `stall` = 0, `cnt` = 0; a re-read of the same address misses again.
- **Both `read_in` and `write_in` asserted on a hit:** write strobe asserted, `read` = 0; with `Enable` = 0, neither a strobe nor a miss occurs.
